// File: rtl/nes_mem_arbiter.sv
// rtl/nes_mem_arbiter.sv - PRG/CHR request arbiter onto one external cartridge-memory port
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   prg_strobe/read/write/aout/allow/din -> prg_dout, prg_done   CPU-side request channel
//   chr_strobe/read/write/aout/allow/din, vram_ce -> chr_dout, chr_done   PPU-side request channel
//   mem_req/mem_we/mem_addr/mem_wdata -> , <- mem_rdata/mem_ack   external req/ack memory port
module nes_mem_arbiter #(
  parameter int         ACK_TIMEOUT = 15,
  parameter logic [7:0] OPEN_BUS    = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        prg_strobe,
  input  logic        prg_read,
  input  logic        prg_write,
  input  logic [21:0] prg_aout,
  input  logic        prg_allow,
  input  logic [7:0]  prg_din,
  output logic [7:0]  prg_dout,
  output logic        prg_done,
  input  logic        chr_strobe,
  input  logic        chr_read,
  input  logic        chr_write,
  input  logic [21:0] chr_aout,
  input  logic        chr_allow,
  input  logic        vram_ce,
  input  logic [7:0]  chr_din,
  output logic [7:0]  chr_dout,
  output logic        chr_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;
  localparam logic [3:0] TIMEOUT_LAST = 4'(ACK_TIMEOUT - 1);

  logic [0:0]  state;
  logic        cur_chr;    // channel owning the access in flight
  logic        prio_chr;   // winner of the next contest (1 = CHR)
  logic [3:0]  tcnt;

  logic        prg_pend, prg_we_q;
  logic [21:0] prg_addr_q;
  logic [7:0]  prg_wdata_q;
  logic        chr_pend, chr_we_q;
  logic [21:0] chr_addr_q;
  logic [7:0]  chr_wdata_q;

  logic        prg_op, chr_op, prg_busy, chr_busy;
  logic        prg_cap, chr_cap, prg_rej, chr_rej;
  logic        prg_req_v, chr_req_v, grant_chr, finish;
  logic        prg_we_n, chr_we_n;
  logic [21:0] prg_addr_n, chr_addr_n;
  logic [7:0]  prg_wdata_n, chr_wdata_n, rd_data;

  always_comb begin
    prg_op   = prg_strobe & (prg_read | prg_write);
    chr_op   = chr_strobe & (chr_read | chr_write);
    // A channel whose access is on the bus drops any new strobe.
    prg_busy = (state == S_ACCESS) & ~cur_chr;
    chr_busy = (state == S_ACCESS) & cur_chr;
    prg_cap  = prg_op & ~prg_busy & prg_allow;
    prg_rej  = prg_op & ~prg_busy & ~prg_allow;
    chr_cap  = chr_op & ~chr_busy & chr_allow & ~vram_ce;
    chr_rej  = chr_op & ~chr_busy & ~(chr_allow & ~vram_ce);
    // Slot view including this cycle's capture, so an idle arbiter can
    // grant a fresh strobe on the same edge that captures it.
    prg_req_v   = prg_pend | prg_cap;
    prg_we_n    = prg_cap ? prg_write : prg_we_q;
    prg_addr_n  = prg_cap ? prg_aout  : prg_addr_q;
    prg_wdata_n = prg_cap ? prg_din   : prg_wdata_q;
    chr_req_v   = chr_pend | chr_cap;
    chr_we_n    = chr_cap ? chr_write : chr_we_q;
    chr_addr_n  = chr_cap ? chr_aout  : chr_addr_q;
    chr_wdata_n = chr_cap ? chr_din   : chr_wdata_q;
    grant_chr = chr_req_v & (~prg_req_v | prio_chr);
    finish    = (state == S_ACCESS) & (mem_ack | (tcnt == TIMEOUT_LAST));
    rd_data   = mem_ack ? mem_rdata : OPEN_BUS;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cur_chr     <= 1'b0;
      prio_chr    <= 1'b1;
      tcnt        <= 4'd0;
      prg_pend    <= 1'b0;
      prg_we_q    <= 1'b0;
      prg_addr_q  <= 22'd0;
      prg_wdata_q <= 8'd0;
      chr_pend    <= 1'b0;
      chr_we_q    <= 1'b0;
      chr_addr_q  <= 22'd0;
      chr_wdata_q <= 8'd0;
      prg_dout    <= 8'h00;
      prg_done    <= 1'b0;
      chr_dout    <= 8'h00;
      chr_done    <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 22'd0;
      mem_wdata   <= 8'd0;
    end else begin
      // Rejected requests complete immediately without touching memory.
      prg_done <= prg_rej;
      chr_done <= chr_rej;
      if (prg_cap) begin
        prg_pend    <= 1'b1;
        prg_we_q    <= prg_write;
        prg_addr_q  <= prg_aout;
        prg_wdata_q <= prg_din;
      end
      if (chr_cap) begin
        chr_pend    <= 1'b1;
        chr_we_q    <= chr_write;
        chr_addr_q  <= chr_aout;
        chr_wdata_q <= chr_din;
      end
      if (state == S_IDLE) begin
        if (prg_req_v | chr_req_v) begin
          state     <= S_ACCESS;
          cur_chr   <= grant_chr;
          tcnt      <= 4'd0;
          mem_req   <= 1'b1;
          mem_we    <= grant_chr ? chr_we_n    : prg_we_n;
          mem_addr  <= grant_chr ? chr_addr_n  : prg_addr_n;
          mem_wdata <= grant_chr ? chr_wdata_n : prg_wdata_n;
          // The pointer only moves when it actually decided a contest.
          if (prg_req_v & chr_req_v) prio_chr <= ~grant_chr;
        end
      end else if (finish) begin
        state   <= S_IDLE;
        tcnt    <= 4'd0;
        mem_req <= 1'b0;
        if (cur_chr) begin
          chr_pend <= 1'b0;
          chr_done <= 1'b1;
          if (!mem_we) chr_dout <= rd_data;
        end else begin
          prg_pend <= 1'b0;
          prg_done <= 1'b1;
          if (!mem_we) prg_dout <= rd_data;
        end
      end else begin
        tcnt <= tcnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// tb/tb_nes_mem_arbiter.sv - self-checking bench for nes_mem_arbiter
module tb_nes_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        prg_strobe, prg_read, prg_write, prg_allow;
  logic [21:0] prg_aout;
  logic [7:0]  prg_din, prg_dout;
  logic        prg_done;
  logic        chr_strobe, chr_read, chr_write, chr_allow, vram_ce;
  logic [21:0] chr_aout;
  logic [7:0]  chr_din, chr_dout;
  logic        chr_done;
  logic        mem_req, mem_we, mem_ack;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  nes_mem_arbiter #(.ACK_TIMEOUT(15), .OPEN_BUS(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n),
    .prg_strobe(prg_strobe), .prg_read(prg_read), .prg_write(prg_write),
    .prg_aout(prg_aout), .prg_allow(prg_allow), .prg_din(prg_din),
    .prg_dout(prg_dout), .prg_done(prg_done),
    .chr_strobe(chr_strobe), .chr_read(chr_read), .chr_write(chr_write),
    .chr_aout(chr_aout), .chr_allow(chr_allow), .vram_ce(vram_ce), .chr_din(chr_din),
    .chr_dout(chr_dout), .chr_done(chr_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic clear_in();
    prg_strobe = 1'b0; prg_read = 1'b0; prg_write = 1'b0; prg_allow = 1'b0;
    prg_aout = 22'd0; prg_din = 8'd0;
    chr_strobe = 1'b0; chr_read = 1'b0; chr_write = 1'b0; chr_allow = 1'b0;
    chr_aout = 22'd0; chr_din = 8'd0; vram_ce = 1'b0;
    mem_ack = 1'b0; mem_rdata = 8'd0;
  endtask

  typedef struct {
    bit          is_chr, rd, wr, allow, vram;
    logic [21:0] addr;
    logic [7:0]  wdata;
    int          delay;      // mem_req cycles before ack (beyond 14 = never)
    logic [7:0]  rdata;
    int          exp_req;    // cycles mem_req is high
    bit          exp_we;
    int          exp_lat;    // strobe-to-done cycles, 0 = no done
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vt[10];

  task automatic run_vec(input vec_t v, input int idx);
    int req_cnt = 0, done_at = 0, ndone = 0, other = 0;
    @(negedge clk);
    if (v.is_chr) begin
      chr_strobe = 1'b1; chr_read = v.rd; chr_write = v.wr; chr_aout = v.addr;
      chr_allow = v.allow; vram_ce = v.vram; chr_din = v.wdata;
    end else begin
      prg_strobe = 1'b1; prg_read = v.rd; prg_write = v.wr; prg_aout = v.addr;
      prg_allow = v.allow; vram_ce = v.vram; prg_din = v.wdata;
    end
    @(negedge clk);
    prg_strobe = 1'b0; chr_strobe = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      if (mem_req) begin
        if (req_cnt == 0) begin
          chk($sformatf("vec%0d_addr", idx), 32'(mem_addr), 32'(v.addr));
          chk($sformatf("vec%0d_we", idx), 32'(mem_we), 32'(v.exp_we));
          if (v.exp_we) chk($sformatf("vec%0d_wdata", idx), 32'(mem_wdata), 32'(v.wdata));
        end
        mem_ack = (req_cnt == v.delay); mem_rdata = v.rdata;
        req_cnt++;
      end else begin
        mem_ack = 1'b0;
      end
      if (v.is_chr ? chr_done : prg_done) begin ndone++; done_at = n; end
      if (v.is_chr ? prg_done : chr_done) other++;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    chk($sformatf("vec%0d_req_cycles", idx), 32'(req_cnt), 32'(v.exp_req));
    chk($sformatf("vec%0d_done_count", idx), 32'(ndone), (v.exp_lat != 0) ? 32'd1 : 32'd0);
    chk($sformatf("vec%0d_latency", idx), 32'(done_at), 32'(v.exp_lat));
    chk($sformatf("vec%0d_other_done", idx), 32'(other), 32'd0);
    chk($sformatf("vec%0d_dout", idx), 32'(v.is_chr ? chr_dout : prg_dout), 32'(v.exp_dout));
  endtask

  task automatic serve(input logic [7:0] rd, output logic [21:0] a, output logic w,
                       output logic [7:0] wd, output bit ok);
    int n = 0;
    while (!mem_req && n < 40) begin @(negedge clk); n++; end
    ok = mem_req; a = mem_addr; w = mem_we; wd = mem_wdata;
    mem_ack = ok; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic pair(input bit prg_first, input logic [7:0] prg_rd, input string tag);
    logic [21:0] a1, a2;
    logic        w1, w2;
    logic [7:0]  d1, d2;
    bit          ok1, ok2;
    @(negedge clk);
    prg_strobe = 1'b1; prg_read = 1'b1; prg_write = 1'b0; prg_aout = 22'h000010;
    prg_allow = 1'b1; prg_din = 8'h00;
    chr_strobe = 1'b1; chr_read = 1'b0; chr_write = 1'b1; chr_aout = 22'h200123;
    chr_allow = 1'b1; vram_ce = 1'b0; chr_din = 8'h3C;
    @(negedge clk);
    prg_strobe = 1'b0; chr_strobe = 1'b0;
    serve(prg_first ? prg_rd : 8'h00, a1, w1, d1, ok1);
    chk({tag, "_first_done"}, 32'(prg_first ? prg_done : chr_done), 32'd1);
    serve(prg_first ? 8'h00 : prg_rd, a2, w2, d2, ok2);
    chk({tag, "_second_done"}, 32'(prg_first ? chr_done : prg_done), 32'd1);
    chk({tag, "_served"}, 32'(ok1 & ok2), 32'd1);
    chk({tag, "_first_addr"}, 32'(a1), prg_first ? 32'h000010 : 32'h200123);
    chk({tag, "_first_we"}, 32'(w1), prg_first ? 32'd0 : 32'd1);
    chk({tag, "_second_addr"}, 32'(a2), prg_first ? 32'h200123 : 32'h000010);
    chk({tag, "_chr_wdata"}, 32'(prg_first ? d2 : d1), 32'h3C);
    chk({tag, "_prg_dout"}, 32'(prg_dout), 32'(prg_rd));
  endtask

  // Reference model: each channel holds at most one outstanding request;
  // a new access must serve an eligible one, and when both are eligible the
  // round-robin winner alternates between contests.
  task automatic random_phase(input int ncyc);
    bit          busy[2], outv[2], upd_v[2];
    int          ostamp[2], exp_done[2];
    logic        owe[2];
    logic [21:0] oaddr[2];
    logic [7:0]  owd[2], exp_dout[2], upd_val[2];
    bit          prio, act, act_to, prev_req, e0, e1;
    int          act_end, ch, kind;
    logic [21:0] act_addr;
    logic        act_we;
    logic [7:0]  act_wd, act_rdata;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; outv[i] = 0; upd_v[i] = 0; exp_done[i] = -1; exp_dout[i] = 8'h00;
    end
    prio = 1; act = 0; act_to = 0; prev_req = 0; act_end = 0;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        logic       d;
        logic [7:0] dv;
        d  = (c == 1) ? chr_done : prg_done;
        dv = (c == 1) ? chr_dout : prg_dout;
        if (exp_done[c] == cyc) begin
          chk($sformatf("rnd_done_ch%0d_cyc%0d", c, cyc), 32'(d), 32'd1);
          exp_done[c] = -1; busy[c] = 0;
          if (upd_v[c]) exp_dout[c] = upd_val[c];
          upd_v[c] = 0;
        end else begin
          chk($sformatf("rnd_no_done_ch%0d_cyc%0d", c, cyc), 32'(d), 32'd0);
        end
        chk($sformatf("rnd_dout_ch%0d_cyc%0d", c, cyc), 32'(dv), 32'(exp_dout[c]));
      end
      if (act && cyc == act_end + 1) begin
        chk($sformatf("rnd_req_drop_cyc%0d", cyc), 32'(mem_req), 32'd0);
        act = 0;
      end
      if (mem_req) begin
        if (act) begin
          chk("rnd_hold_addr", 32'(mem_addr), 32'(act_addr));
          chk("rnd_hold_we", 32'(mem_we), 32'(act_we));
          if (act_we) chk("rnd_hold_wdata", 32'(mem_wdata), 32'(act_wd));
        end else begin
          chk($sformatf("rnd_req_gap_cyc%0d", cyc), 32'(prev_req), 32'd0);
          e0 = outv[0] && ostamp[0] < cyc;
          e1 = outv[1] && ostamp[1] < cyc;
          chk($sformatf("rnd_req_cause_cyc%0d", cyc), 32'(e0 | e1), 32'd1);
          if (e0 | e1) begin
            ch = (e0 && e1) ? int'(prio) : (e1 ? 1 : 0);
            if (e0 && e1) prio = (ch == 0);
            chk($sformatf("rnd_addr_cyc%0d", cyc), 32'(mem_addr), 32'(oaddr[ch]));
            chk($sformatf("rnd_we_cyc%0d", cyc), 32'(mem_we), 32'(owe[ch]));
            if (owe[ch]) chk($sformatf("rnd_wdata_cyc%0d", cyc), 32'(mem_wdata), 32'(owd[ch]));
            act = 1; outv[ch] = 0;
            act_addr = oaddr[ch]; act_we = owe[ch]; act_wd = owd[ch];
            act_to = ($urandom_range(0, 9) == 0);
            act_end = act_to ? cyc + 14 : cyc + int'($urandom_range(0, 5));
            act_rdata = 8'($urandom);
            exp_done[ch] = act_end + 1;
            upd_v[ch] = !owe[ch];
            upd_val[ch] = act_to ? 8'hFF : act_rdata;
          end
        end
      end
      mem_ack = 1'b0; mem_rdata = 8'($urandom);
      if (act && cyc == act_end && !act_to) begin
        mem_ack = 1'b1; mem_rdata = act_rdata;
      end else if (!mem_req && $urandom_range(0, 5) == 0) begin
        mem_ack = 1'b1;
      end
      prg_strobe = 1'b0; chr_strobe = 1'b0; vram_ce = 1'($urandom);
      if (cyc < ncyc - 60) begin
        for (int c = 0; c < 2; c++) begin
          if (!busy[c] && $urandom_range(0, 3) == 0) begin
            logic        rd, wr, al, vr;
            logic [21:0] a;
            logic [7:0]  wd;
            kind = int'($urandom_range(0, 7));
            rd = (kind >= 1 && kind <= 3) || kind == 7;
            wr = kind >= 4;
            al = ($urandom_range(0, 5) != 0);
            vr = (c == 1) && ($urandom_range(0, 5) == 0);
            a = 22'($urandom); wd = 8'($urandom);
            if (c == 1) begin
              chr_strobe = 1'b1; chr_read = rd; chr_write = wr; chr_aout = a;
              chr_allow = al; chr_din = wd; vram_ce = vr;
            end else begin
              prg_strobe = 1'b1; prg_read = rd; prg_write = wr; prg_aout = a;
              prg_allow = al; prg_din = wd;
            end
            if (rd | wr) begin
              busy[c] = 1;
              if (al && !vr) begin
                outv[c] = 1; ostamp[c] = cyc; owe[c] = wr; oaddr[c] = a; owd[c] = wd;
              end else begin
                exp_done[c] = cyc + 1; upd_v[c] = 0;
              end
            end
          end
        end
      end
      prev_req = mem_req;
    end
    clear_in();
    chk("rnd_drain", 32'(busy[0] | busy[1] | act), 32'd0);
  endtask

  initial begin
    int cnt;
    bit seen, bad;
    clear_in();
    reset_n = 1'b0;
    vt[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 22'h007FFC, 8'h00, 3,  8'hA5, 4,  1'b0, 5,  8'hA5};
    vt[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 22'h001234, 8'h99, 0,  8'h00, 0,  1'b0, 1,  8'hA5};
    vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 22'h000040, 8'h00, 0,  8'h00, 0,  1'b0, 1,  8'h00};
    vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 22'h000ABC, 8'h00, 0,  8'hC3, 1,  1'b0, 2,  8'hC3};
    vt[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 22'h3FFFFF, 8'h5E, 1,  8'h11, 2,  1'b1, 3,  8'hA5};
    vt[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 22'h155555, 8'hE7, 2,  8'h22, 3,  1'b1, 4,  8'hC3};
    vt[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 22'h2AAAAA, 8'h00, 99, 8'h44, 15, 1'b0, 16, 8'hFF};
    vt[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 22'h000777, 8'h00, 0,  8'h00, 0,  1'b0, 1,  8'hC3};
    vt[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 22'h3000FF, 8'h00, 14, 8'h81, 15, 1'b0, 16, 8'h81};
    vt[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 22'h000001, 8'h00, 0,  8'h00, 0,  1'b0, 0,  8'hFF};

    repeat (3) @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_outputs", 32'(|{mem_we, mem_addr, mem_wdata, prg_done, chr_done}), 32'd0);
    chk("rst_prg_dout", 32'(prg_dout), 32'h00);
    chk("rst_chr_dout", 32'(chr_dout), 32'h00);
    reset_n = 1'b1;

    pair(1'b0, 8'h5A, "pair1");
    pair(1'b1, 8'h77, "pair2");

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Timeout followed by a late acknowledge.
    @(negedge clk);
    prg_strobe = 1'b1; prg_read = 1'b1; prg_write = 1'b0; prg_aout = 22'h012345; prg_allow = 1'b1;
    @(negedge clk);
    prg_strobe = 1'b0;
    cnt = 0; seen = 0;
    for (int n = 0; n < 30 && !seen; n++) begin
      if (prg_done) seen = 1;
      else begin
        if (mem_req) cnt++;
        @(negedge clk);
      end
    end
    chk("to_done_seen", 32'(seen), 32'd1);
    chk("to_req_cycles", 32'(cnt), 32'd15);
    chk("to_open_bus", 32'(prg_dout), 32'hFF);
    chk("to_req_low", 32'(mem_req), 32'd0);
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 8'h12;
    @(negedge clk);
    mem_ack = 1'b0;
    bad = 0;
    for (int n = 0; n < 6; n++) begin
      bad |= prg_done | chr_done | mem_req;
      @(negedge clk);
    end
    chk("late_ack_ignored", 32'(bad), 32'd0);
    chk("late_ack_dout", 32'(prg_dout), 32'hFF);

    // Reset while an access is on the bus.
    chr_strobe = 1'b1; chr_read = 1'b1; chr_write = 1'b0; chr_aout = 22'h0000AA;
    chr_allow = 1'b1; vram_ce = 1'b0;
    @(negedge clk);
    chr_strobe = 1'b0;
    chk("rstmid_req_before", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("rstmid_req_async", 32'(mem_req), 32'd0);
    chk("rstmid_outputs", 32'(|{mem_we, mem_addr, mem_wdata, prg_done, chr_done, prg_dout, chr_dout}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      bad |= mem_req | prg_done | chr_done;
    end
    chk("rstmid_quiet_after", 32'(bad), 32'd0);

    random_phase(3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
